// File: rtl/obi_bus_arbiter.sv
// Two-host (instruction/data) to one-device OBI arbiter with round-robin grant,
// grant-wait lock, and an in-order source-ID FIFO that routes device responses.
module obi_bus_arbiter #(
    parameter int MaxOutstanding = 2
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        dev_req_o,
    output logic        dev_we_o,
    output logic [3:0]  dev_be_o,
    output logic [31:0] dev_addr_o,
    output logic [31:0] dev_wdata_o,
    input  logic        dev_gnt_i,
    input  logic        dev_rvalid_i,
    input  logic [31:0] dev_rdata_i,
    input  logic        dev_err_i,

    output logic [2:0]  outstanding_o,
    output logic        protocol_err_o
);

    logic [MaxOutstanding-1:0] r_fifo;
    logic [MaxOutstanding-1:0] w_fifo_next;
    logic [2:0]                r_count;
    logic                      r_rr_next;
    logic                      r_lock_valid;
    logic                      r_lock_src;
    logic                      r_protocol_err;

    logic       w_sel_data;
    logic       w_sel_req;
    logic       w_has_slot;
    logic       w_push;
    logic       w_pop;
    logic       w_head;
    logic [2:0] w_wr_idx;

    // Source selection: a pending (ungranted) request keeps its source locked.
    always_comb begin
        w_sel_data = r_rr_next;
        if (r_lock_valid) begin
            w_sel_data = r_lock_src;
        end else if (data_req_i && !instr_req_i) begin
            w_sel_data = 1'b1;
        end else if (instr_req_i && !data_req_i) begin
            w_sel_data = 1'b0;
        end
    end

    assign w_sel_req  = w_sel_data ? data_req_i : instr_req_i;
    assign w_has_slot = (r_count < 3'(MaxOutstanding));

    assign dev_req_o   = w_sel_req && w_has_slot;
    assign dev_we_o    = w_sel_data ? data_we_i    : 1'b0;
    assign dev_be_o    = w_sel_data ? data_be_i    : 4'hF;
    assign dev_addr_o  = w_sel_data ? data_addr_i  : instr_addr_i;
    assign dev_wdata_o = w_sel_data ? data_wdata_i : 32'h0;

    assign w_push = dev_req_o && dev_gnt_i;
    assign w_pop  = dev_rvalid_i && (r_count != 3'd0);
    assign w_head = r_fifo[0];

    assign instr_gnt_o = w_push && !w_sel_data;
    assign data_gnt_o  = w_push &&  w_sel_data;

    assign instr_rvalid_o = w_pop && !w_head;
    assign data_rvalid_o  = w_pop &&  w_head;
    assign instr_rdata_o  = dev_rdata_i;
    assign data_rdata_o   = dev_rdata_i;
    assign instr_err_o    = dev_err_i && instr_rvalid_o;
    assign data_err_o     = dev_err_i && data_rvalid_o;

    assign outstanding_o  = r_count;
    assign protocol_err_o = r_protocol_err;

    // Head lives at index 0; a pop shifts down, and the push lands after the
    // surviving entries so a simultaneous push/pop on one entry becomes the head.
    assign w_wr_idx = r_count - {2'b00, w_pop};

    generate
        for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_fifo
            logic w_shift_in;
            if (gi + 1 < MaxOutstanding) begin : g_mid
                assign w_shift_in = r_fifo[gi+1];
            end else begin : g_last
                assign w_shift_in = 1'b0;
            end
            assign w_fifo_next[gi] = (w_push && (w_wr_idx == 3'(gi))) ? w_sel_data :
                                     w_pop                             ? w_shift_in :
                                                                         r_fifo[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fifo         <= '0;
            r_count        <= 3'd0;
            r_rr_next      <= 1'b1;
            r_lock_valid   <= 1'b0;
            r_lock_src     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_fifo  <= w_fifo_next;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
            if (w_push) begin
                r_rr_next    <= ~w_sel_data;
                r_lock_valid <= 1'b0;
            end else if (dev_req_o) begin
                r_lock_valid <= 1'b1;
                r_lock_src   <= w_sel_data;
            end
            if (dev_rvalid_i && (r_count == 3'd0)) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_bus_arbiter.sv
// Directed bench for obi_bus_arbiter: drives both hosts and a hand-scripted
// device, checking grants, attribute muxing, lock, ordering, full and stray cases.
module tb_obi_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        dev_req_o;
    logic        dev_we_o;
    logic [3:0]  dev_be_o;
    logic [31:0] dev_addr_o;
    logic [31:0] dev_wdata_o;
    logic        dev_gnt_i;
    logic        dev_rvalid_i;
    logic [31:0] dev_rdata_i;
    logic        dev_err_i;
    logic [2:0]  outstanding_o;
    logic        protocol_err_o;

    int checks = 0;
    int errors = 0;

    obi_bus_arbiter #(.MaxOutstanding(2)) dut (
        .clock(clock), .reset(reset),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_be_o(dev_be_o),
        .dev_addr_o(dev_addr_o), .dev_wdata_o(dev_wdata_o), .dev_gnt_i(dev_gnt_i),
        .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_req_i = 1'b0; instr_addr_i = 32'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'h0; data_wdata_i = 32'h0;
        dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_rdata_i = 32'h0; dev_err_i = 1'b0;
        tick(); tick(); settle();
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding_o); end
        checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL reset_protocol_err: got %b expected 0", protocol_err_o); end
        checks++; if (dev_req_o !== 1'b0) begin errors++; $display("FAIL reset_dev_req: got %b expected 0", dev_req_o); end
        checks++; if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 4'b0000) begin errors++; $display("FAIL reset_host_outputs: got %b expected 0000", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}); end
        reset = 1'b0;
        settle();
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL release_outstanding: got %0d expected 0", outstanding_o); end
        $display("test_reset done: outstanding=%0d protocol_err=%b", outstanding_o, protocol_err_o);
    endtask

    task automatic test_single_host();
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h100; dev_gnt_i = 1'b1;
        settle();
        checks++; if (dev_req_o !== 1'b1) begin errors++; $display("FAIL single_dev_req: got %b expected 1", dev_req_o); end
        checks++; if (dev_addr_o !== 32'h100) begin errors++; $display("FAIL single_dev_addr: got %h expected 00000100", dev_addr_o); end
        checks++; if (dev_be_o !== 4'hF) begin errors++; $display("FAIL single_dev_be: got %h expected f", dev_be_o); end
        checks++; if (dev_we_o !== 1'b0) begin errors++; $display("FAIL single_dev_we: got %b expected 0", dev_we_o); end
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL single_gnt: got %b expected 10", {instr_gnt_o, data_gnt_o}); end
        tick();
        instr_req_i = 1'b0; dev_gnt_i = 1'b0;
        settle();
        checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL single_outstanding: got %0d expected 1", outstanding_o); end
        tick();
        dev_rvalid_i = 1'b1; dev_rdata_i = 32'hDEADBEEF;
        settle();
        checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL single_instr_rvalid: got %b expected 1", instr_rvalid_o); end
        checks++; if (instr_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_instr_rdata: got %h expected deadbeef", instr_rdata_o); end
        checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL single_data_rvalid: got %b expected 0", data_rvalid_o); end
        checks++; if (data_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data_rdata: got %h expected deadbeef", data_rdata_o); end
        tick();
        dev_rvalid_i = 1'b0;
        settle();
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL single_drained: got %0d expected 0", outstanding_o); end
        $display("test_single_host done: rdata=%h", instr_rdata_o);
    endtask

    task automatic test_contention();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h1000;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h2000;
        dev_gnt_i = 1'b1;
        settle();
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin errors++; $display("FAIL cont_c0_gnt: got %b expected 01", {instr_gnt_o, data_gnt_o}); end
        checks++; if (dev_addr_o !== 32'h2000) begin errors++; $display("FAIL cont_c0_addr: got %h expected 00002000", dev_addr_o); end
        tick(); settle();
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL cont_c1_gnt: got %b expected 10", {instr_gnt_o, data_gnt_o}); end
        checks++; if (dev_addr_o !== 32'h1000) begin errors++; $display("FAIL cont_c1_addr: got %h expected 00001000", dev_addr_o); end
        tick(); settle();
        checks++; if ({dev_req_o, instr_gnt_o, data_gnt_o} !== 3'b000) begin errors++; $display("FAIL cont_c2_stall: got %b expected 000", {dev_req_o, instr_gnt_o, data_gnt_o}); end
        checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL cont_c2_outstanding: got %0d expected 2", outstanding_o); end
        tick();
        dev_rvalid_i = 1'b1;
        settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o, dev_req_o} !== 3'b010) begin errors++; $display("FAIL cont_c3_resp: got %b expected 010", {instr_rvalid_o, data_rvalid_o, dev_req_o}); end
        tick();
        dev_rvalid_i = 1'b0;
        settle();
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin errors++; $display("FAIL cont_c4_gnt: got %b expected 01", {instr_gnt_o, data_gnt_o}); end
        checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL cont_c4_outstanding: got %0d expected 1", outstanding_o); end
        tick();
        dev_rvalid_i = 1'b1;
        settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o, dev_req_o} !== 3'b100) begin errors++; $display("FAIL cont_c5_resp: got %b expected 100", {instr_rvalid_o, data_rvalid_o, dev_req_o}); end
        tick();
        dev_rvalid_i = 1'b0;
        settle();
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL cont_c6_gnt: got %b expected 10", {instr_gnt_o, data_gnt_o}); end
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin errors++; $display("FAIL cont_c7_resp: got %b expected 01", {instr_rvalid_o, data_rvalid_o}); end
        checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL cont_c7_outstanding: got %0d expected 2", outstanding_o); end
        tick(); settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL cont_c8_resp: got %b expected 10", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        dev_rvalid_i = 1'b0;
        settle();
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL cont_drained: got %0d expected 0", outstanding_o); end
        $display("test_contention done: order D I D I observed with stalls");
    endtask

    task automatic test_lock();
        // One data transaction first so the round-robin pointer prefers instr.
        tick();
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h2000; dev_gnt_i = 1'b1;
        tick();
        data_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        tick();
        dev_rvalid_i = 1'b0;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3; data_addr_i = 32'h200; data_wdata_i = 32'h12345678;
        settle();
        checks++; if ({dev_req_o, dev_we_o, dev_be_o} !== {1'b1, 1'b1, 4'h3}) begin errors++; $display("FAIL lock_c0_attr: got req/we/be %b/%b/%h expected 1/1/3", dev_req_o, dev_we_o, dev_be_o); end
        checks++; if (dev_wdata_o !== 32'h12345678) begin errors++; $display("FAIL lock_c0_wdata: got %h expected 12345678", dev_wdata_o); end
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL lock_c0_outstanding: got %0d expected 0", outstanding_o); end
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h300;
        settle();
        checks++; if (dev_addr_o !== 32'h200) begin errors++; $display("FAIL lock_c1_addr: got %h expected 00000200", dev_addr_o); end
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin errors++; $display("FAIL lock_c1_gnt: got %b expected 00", {instr_gnt_o, data_gnt_o}); end
        tick(); settle();
        checks++; if (dev_addr_o !== 32'h200) begin errors++; $display("FAIL lock_c2_addr: got %h expected 00000200", dev_addr_o); end
        tick();
        dev_gnt_i = 1'b1;
        settle();
        checks++; if (dev_addr_o !== 32'h200) begin errors++; $display("FAIL lock_c3_addr: got %h expected 00000200", dev_addr_o); end
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin errors++; $display("FAIL lock_c3_gnt: got %b expected 01", {instr_gnt_o, data_gnt_o}); end
        tick(); settle();
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL lock_c4_gnt: got %b expected 10", {instr_gnt_o, data_gnt_o}); end
        checks++; if ({dev_addr_o, dev_be_o, dev_we_o} !== {32'h300, 4'hF, 1'b0}) begin errors++; $display("FAIL lock_c4_attr: got addr/be/we %h/%h/%b expected 00000300/f/0", dev_addr_o, dev_be_o, dev_we_o); end
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin errors++; $display("FAIL lock_resp0: got %b expected 01", {instr_rvalid_o, data_rvalid_o}); end
        tick(); settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL lock_resp1: got %b expected 10", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        dev_rvalid_i = 1'b0;
        data_we_i = 1'b0; data_be_i = 4'hF;
        $display("test_lock done: data address held through 3 wait cycles");
    endtask

    task automatic test_ordering();
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h400; dev_gnt_i = 1'b1;
        settle();
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL order_issue_instr: got %b expected 10", {instr_gnt_o, data_gnt_o}); end
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h500;
        settle();
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin errors++; $display("FAIL order_issue_data: got %b expected 01", {instr_gnt_o, data_gnt_o}); end
        tick();
        data_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1; dev_err_i = 1'b0; dev_rdata_i = 32'h11111111;
        settle();
        checks++; if ({instr_rvalid_o, instr_err_o, data_rvalid_o} !== 3'b100) begin errors++; $display("FAIL order_resp_instr: got rvalid/err/drvalid %b expected 100", {instr_rvalid_o, instr_err_o, data_rvalid_o}); end
        checks++; if (instr_rdata_o !== 32'h11111111) begin errors++; $display("FAIL order_instr_rdata: got %h expected 11111111", instr_rdata_o); end
        tick();
        dev_err_i = 1'b1; dev_rdata_i = 32'h22222222;
        settle();
        checks++; if ({data_rvalid_o, data_err_o, instr_rvalid_o, instr_err_o} !== 4'b1100) begin errors++; $display("FAIL order_resp_data: got %b expected 1100", {data_rvalid_o, data_err_o, instr_rvalid_o, instr_err_o}); end
        checks++; if (data_rdata_o !== 32'h22222222) begin errors++; $display("FAIL order_data_rdata: got %h expected 22222222", data_rdata_o); end
        tick();
        dev_rvalid_i = 1'b0; dev_err_i = 1'b0;
        settle();
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL order_drained: got %0d expected 0", outstanding_o); end
        $display("test_ordering done: instr then data, err on data only");
    endtask

    task automatic test_full();
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h600; data_req_i = 1'b1; data_addr_i = 32'h700; dev_gnt_i = 1'b1;
        settle();
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL full_c0_gnt: got %b expected 10", {instr_gnt_o, data_gnt_o}); end
        tick(); settle();
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin errors++; $display("FAIL full_c1_gnt: got %b expected 01", {instr_gnt_o, data_gnt_o}); end
        tick(); settle();
        checks++; if (dev_req_o !== 1'b0) begin errors++; $display("FAIL full_c2_dev_req: got %b expected 0", dev_req_o); end
        checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL full_c2_outstanding: got %0d expected 2", outstanding_o); end
        tick();
        dev_rvalid_i = 1'b1;
        settle();
        checks++; if ({instr_rvalid_o, dev_req_o, instr_gnt_o, data_gnt_o} !== 4'b1000) begin errors++; $display("FAIL full_c3_pop_no_issue: got %b expected 1000", {instr_rvalid_o, dev_req_o, instr_gnt_o, data_gnt_o}); end
        tick();
        dev_rvalid_i = 1'b0;
        settle();
        checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL full_c4_outstanding: got %0d expected 1", outstanding_o); end
        checks++; if ({dev_req_o, instr_gnt_o, data_gnt_o} !== 3'b110) begin errors++; $display("FAIL full_c4_issue: got %b expected 110", {dev_req_o, instr_gnt_o, data_gnt_o}); end
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin errors++; $display("FAIL full_drain0: got %b expected 01", {instr_rvalid_o, data_rvalid_o}); end
        tick(); settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL full_drain1: got %b expected 10", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        dev_rvalid_i = 1'b0;
        settle();
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", outstanding_o); end
        $display("test_full done: issue held while full, resumed next cycle");
    endtask

    task automatic test_stray_reset();
        tick();
        dev_rvalid_i = 1'b1; dev_err_i = 1'b1;
        settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o} !== 4'b0000) begin errors++; $display("FAIL stray_no_rvalid: got %b expected 0000", {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}); end
        checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL stray_err_same_cycle: got %b expected 0", protocol_err_o); end
        tick();
        dev_rvalid_i = 1'b0; dev_err_i = 1'b0;
        settle();
        checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL stray_err_next_cycle: got %b expected 1", protocol_err_o); end
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL stray_outstanding: got %0d expected 0", outstanding_o); end
        instr_req_i = 1'b1; instr_addr_i = 32'h800; dev_gnt_i = 1'b1;
        settle();
        checks++; if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL stray_issue: got %b expected 1", instr_gnt_o); end
        tick();
        instr_req_i = 1'b0; dev_gnt_i = 1'b0;
        settle();
        checks++; if ({outstanding_o, protocol_err_o} !== {3'd1, 1'b1}) begin errors++; $display("FAIL stray_sticky: got outstanding/perr %0d/%b expected 1/1", outstanding_o, protocol_err_o); end
        reset = 1'b1;
        tick();
        settle();
        checks++; if ({outstanding_o, protocol_err_o} !== {3'd0, 1'b0}) begin errors++; $display("FAIL midflight_reset: got outstanding/perr %0d/%b expected 0/0", outstanding_o, protocol_err_o); end
        reset = 1'b0;
        dev_rvalid_i = 1'b1;
        settle();
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL post_reset_stray_rvalid: got %b expected 00", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        dev_rvalid_i = 1'b0;
        settle();
        checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL post_reset_stray_err: got %b expected 1", protocol_err_o); end
        $display("test_stray_reset done: protocol_err=%b", protocol_err_o);
    endtask

    initial begin
        test_reset();
        test_single_host();
        test_contention();
        test_lock();
        test_ordering();
        test_full();
        test_stray_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
